// File: rtl/bot_irq_ctrl.sv
// bot_irq_ctrl: interrupt controller for a KCPSM6 picoblaze.
// Three edge-detected external sources plus an internal periodic timer feed
// a pending register; a small FSM raises one interrupt at a time and waits
// for software to acknowledge and then write end-of-interrupt.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | no interrupt outstanding; watching PEND & MASK
//   S_ASSERT  | interrupt high, waiting for interrupt_ack
//   S_SERVICE | handler running; new pending held off until EOI write
module bot_irq_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         PRESCALE  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  input  logic [2:0] irq_src,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [7:0] A_PEND  = BASE_ADDR;
  localparam logic [7:0] A_MASK  = BASE_ADDR + 8'd1;
  localparam logic [7:0] A_CAUSE = BASE_ADDR + 8'd2;
  localparam logic [7:0] A_EOI   = BASE_ADDR + 8'd3;
  localparam logic [7:0] A_TPER  = BASE_ADDR + 8'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_irq_d;
  logic [3:0]      r_pend;
  logic [3:0]      r_mask_en;
  logic            r_mask_gie;
  logic [1:0]      r_cause_id;
  logic [7:0]      r_tper;
  logic [PW-1:0]   r_pre;
  logic [7:0]      r_tick;
  logic [7:0]      r_in_port;

  logic            w_wr_pend;
  logic            w_wr_mask;
  logic            w_wr_eoi;
  logic            w_wr_tper;
  logic [2:0]      w_edge;
  logic            w_pre_wrap;
  logic [7:0]      w_tick_inc;
  logic            w_tmr_set;
  logic [3:0]      w_pend_set;
  logic [3:0]      w_pend_clr;
  logic [3:0]      w_qual;
  logic [1:0]      w_low_id;
  logic            w_latch;
  logic [3:0]      w_ack_clr;
  logic            w_unused;

  // Reads are side-effect free, so the strobe carries no information here.
  assign w_unused = read_strobe;

  assign w_wr_pend = write_strobe && (port_id == A_PEND);
  assign w_wr_mask = write_strobe && (port_id == A_MASK);
  assign w_wr_eoi  = write_strobe && (port_id == A_EOI);
  assign w_wr_tper = write_strobe && (port_id == A_TPER);

  assign w_edge     = irq_src & ~r_irq_d;
  assign w_pre_wrap = (r_pre == PRE_MAX);
  assign w_tick_inc = r_tick + 8'd1;
  // Compare against the incremented value so the set lands on the same
  // edge the tick counter would reach TPER (TPER*PRESCALE cycles exactly).
  assign w_tmr_set  = (r_tper != 8'd0) && w_pre_wrap && (w_tick_inc == r_tper);
  assign w_pend_set = {w_tmr_set, w_edge};
  assign w_pend_clr = (w_wr_pend ? out_port[3:0] : 4'd0) | w_ack_clr;
  assign w_qual     = r_pend & r_mask_en;

  assign interrupt  = (r_state == S_ASSERT);
  assign in_port    = r_in_port;

  // Lowest-index qualifying source wins.
  always_comb begin
    w_low_id = 2'd0;
    if (w_qual[0])      w_low_id = 2'd0;
    else if (w_qual[1]) w_low_id = 2'd1;
    else if (w_qual[2]) w_low_id = 2'd2;
    else if (w_qual[3]) w_low_id = 2'd3;
  end

  // FSM next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ack_clr   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (r_mask_gie && (w_qual != 4'd0)) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!r_mask_gie) begin
          w_state_nxt = S_IDLE;
        end else if (interrupt_ack) begin
          w_ack_clr[r_cause_id] = 1'b1;
          w_state_nxt           = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (w_wr_eoi) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Edge detect, pending bits (set beats clear), cause latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_d    <= 3'd0;
      r_pend     <= 4'd0;
      r_cause_id <= 2'd0;
    end else begin
      r_irq_d <= irq_src;
      r_pend  <= (r_pend & ~w_pend_clr) | w_pend_set;
      if (w_latch) r_cause_id <= w_low_id;
    end
  end

  // Software-writable configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask_en  <= 4'd0;
      r_mask_gie <= 1'b0;
      r_tper     <= 8'd0;
    end else begin
      if (w_wr_mask) begin
        r_mask_en  <= out_port[3:0];
        r_mask_gie <= out_port[7];
      end
      if (w_wr_tper) r_tper <= out_port;
    end
  end

  // Prescaler and tick counter; idle at zero while the timer is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 8'd0;
    end else if (w_wr_tper || (r_tper == 8'd0)) begin
      r_pre  <= '0;
      r_tick <= 8'd0;
    end else if (w_pre_wrap) begin
      r_pre  <= '0;
      r_tick <= w_tmr_set ? 8'd0 : w_tick_inc;
    end else begin
      r_pre  <= r_pre + PW'(1);
    end
  end

  // Registered read mux; zero outside the block so it can be OR-combined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_port <= 8'h00;
    end else begin
      case (port_id)
        A_PEND:  r_in_port <= {4'd0, r_pend};
        A_MASK:  r_in_port <= {r_mask_gie, 3'd0, r_mask_en};
        A_CAUSE: r_in_port <= {(r_state == S_SERVICE), 5'd0, r_cause_id};
        A_TPER:  r_in_port <= r_tper;
        default: r_in_port <= 8'h00;
      endcase
    end
  end

endmodule
